// File: rtl/axi4_stream_if.sv
// AXI4-Stream interface bundle.
//
// Carries one stream beat with all optional AXI4-Stream sideband fields. The producer
// uses the master modport and the consumer uses the slave modport.
//
// Parameters:
//   DATA_WIDTH  tdata width in bits (multiple of 8); tstrb/tkeep are DATA_WIDTH/8 wide
//   ID_WIDTH    tid width
//   DEST_WIDTH  tdest width
//   USER_WIDTH  tuser width
//
// Signals: tvalid, tready, tdata, tstrb, tkeep, tlast, tid, tdest, tuser
interface axi4_stream_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned DEST_WIDTH = 4,
  parameter int unsigned USER_WIDTH = 4
);

  logic                      tvalid;
  logic                      tready;
  logic [DATA_WIDTH-1:0]     tdata;
  logic [DATA_WIDTH/8-1:0]   tstrb;
  logic [DATA_WIDTH/8-1:0]   tkeep;
  logic                      tlast;
  logic [ID_WIDTH-1:0]       tid;
  logic [DEST_WIDTH-1:0]     tdest;
  logic [USER_WIDTH-1:0]     tuser;

  modport master (
    output tvalid,
    output tdata,
    output tstrb,
    output tkeep,
    output tlast,
    output tid,
    output tdest,
    output tuser,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tstrb,
    input  tkeep,
    input  tlast,
    input  tid,
    input  tdest,
    input  tuser,
    output tready
  );

endinterface

// File: rtl/axi4_stream_fifo.sv
// AXI4-Stream FIFO with optional store-and-forward packet mode.
//
// Buffers every stream field through a DEPTH-entry first-word-fall-through FIFO.
// In packet mode the output is held back until a complete packet (tlast) is stored;
// a packet longer than DEPTH would otherwise deadlock, so once the FIFO fills without
// any complete packet inside, the oversize packet is streamed through (cut-through)
// until its tlast leaves.
//
// Parameters:
//   DATA_WIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH  stream field widths
//   DEPTH        number of entries, power of two, >= 2
//   PACKET_MODE  0 = plain stream FIFO, 1 = store-and-forward
//
// Ports:
//   aclk          clock, rising edge
//   areset        asynchronous active-high reset
//   pkt_i         input stream (slave)
//   pkt_o         output stream (master), fields driven from the head entry
//   used_words_o  occupied entries, 0..DEPTH
//   full_o        used_words_o == DEPTH
//   empty_o       used_words_o == 0
module axi4_stream_fifo #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ID_WIDTH    = 8,
  parameter int unsigned DEST_WIDTH  = 4,
  parameter int unsigned USER_WIDTH  = 4,
  parameter int unsigned DEPTH       = 16,
  parameter bit          PACKET_MODE = 1'b0
) (
  input  logic                   aclk,
  input  logic                   areset,
  axi4_stream_if.slave           pkt_i,
  axi4_stream_if.master          pkt_o,
  output logic [$clog2(DEPTH):0] used_words_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned ADDR_W  = $clog2(DEPTH);
  localparam int unsigned STRB_W  = DATA_WIDTH / 8;
  localparam int unsigned ENTRY_W = DATA_WIDTH + 2 * STRB_W + 1 + ID_WIDTH + DEST_WIDTH
                                    + USER_WIDTH;

  // Pointers carry one extra MSB so they run modulo 2*DEPTH.
  typedef logic [ADDR_W:0]    ptr_t;
  typedef logic [ENTRY_W-1:0] entry_t;

  localparam ptr_t DEPTH_PTR = ptr_t'(DEPTH);
  localparam ptr_t PTR_ONE   = ptr_t'(1);

  entry_t mem_q [DEPTH];
  entry_t wr_entry;
  entry_t rd_entry;

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t used_q, used_d;
  ptr_t pkt_cnt_q, pkt_cnt_d;
  logic cut_thru_q, cut_thru_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic push_last;
  logic pop_last;
  logic release_ok;

  // ---------------------------------------------------------------------------
  // Status and handshakes
  // ---------------------------------------------------------------------------
  assign full  = (used_q == DEPTH_PTR);
  assign empty = (used_q == '0);

  assign used_words_o = used_q;
  assign full_o       = full;
  assign empty_o      = empty;

  // Only registered state and areset feed tready: no path from pkt_o.tready.
  assign pkt_i.tready = !full && !areset;
  assign push         = pkt_i.tvalid && pkt_i.tready;

  // Stream mode releases any stored word; packet mode needs a whole packet stored
  // or an active cut-through of an oversize packet.
  assign release_ok   = !PACKET_MODE || (pkt_cnt_q != '0) || cut_thru_q;
  assign pkt_o.tvalid = !empty && release_ok;
  assign pop          = pkt_o.tvalid && pkt_o.tready;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  assign wr_entry = {pkt_i.tdata, pkt_i.tstrb, pkt_i.tkeep, pkt_i.tlast,
                     pkt_i.tid, pkt_i.tdest, pkt_i.tuser};

  assign rd_entry = mem_q[rd_ptr_q[ADDR_W-1:0]];

  assign {pkt_o.tdata, pkt_o.tstrb, pkt_o.tkeep, pkt_o.tlast,
          pkt_o.tid, pkt_o.tdest, pkt_o.tuser} = rd_entry;

  assign push_last = push && pkt_i.tlast;
  assign pop_last  = pop && pkt_o.tlast;

  // Storage is deliberately not reset; only pointers define validity.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    used_d     = used_q;
    pkt_cnt_d  = pkt_cnt_q;
    cut_thru_d = cut_thru_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    unique case ({push, pop})
      2'b10:   used_d = used_q + PTR_ONE;
      2'b01:   used_d = used_q - PTR_ONE;
      default: used_d = used_q;
    endcase

    unique case ({push_last, pop_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + PTR_ONE;
      2'b01:   pkt_cnt_d = pkt_cnt_q - PTR_ONE;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase

    // Full with no complete packet inside can only be an oversize packet: stream it
    // out until its tlast leaves. Setting wins over clearing.
    if (PACKET_MODE && full && (pkt_cnt_q == '0)) begin
      cut_thru_d = 1'b1;
    end else if (pop_last) begin
      cut_thru_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      used_q     <= '0;
      pkt_cnt_q  <= '0;
      cut_thru_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      used_q     <= used_d;
      pkt_cnt_q  <= pkt_cnt_d;
      cut_thru_q <= cut_thru_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Invariants: the occupancy counter always equals the pointer distance and
  // never exceeds the buffer size.
  // ---------------------------------------------------------------------------
  occupancy_matches_ptrs : assert property (
    @(posedge aclk) used_q == ptr_t'(wr_ptr_q - rd_ptr_q)
  );

  occupancy_bounded : assert property (
    @(posedge aclk) used_q <= DEPTH_PTR
  );

endmodule

// File: tb/tb_axi4_stream_fifo.sv
module tb_axi4_stream_fifo;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic       areset;
  logic [4:0] s_used;
  logic       s_full, s_empty;
  logic [3:0] p_used;
  logic       p_full, p_empty;

  axi4_stream_if s_in ();
  axi4_stream_if s_out ();
  axi4_stream_if p_in ();
  axi4_stream_if p_out ();

  axi4_stream_fifo #(
    .DEPTH       (16),
    .PACKET_MODE (1'b0)
  ) u_str (
    .aclk         (aclk),
    .areset       (areset),
    .pkt_i        (s_in),
    .pkt_o        (s_out),
    .used_words_o (s_used),
    .full_o       (s_full),
    .empty_o      (s_empty)
  );

  axi4_stream_fifo #(
    .DEPTH       (8),
    .PACKET_MODE (1'b1)
  ) u_pkt (
    .aclk         (aclk),
    .areset       (areset),
    .pkt_i        (p_in),
    .pkt_o        (p_out),
    .used_words_o (p_used),
    .full_o       (p_full),
    .empty_o      (p_empty)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int s_popped = 0;

  logic [56:0] sq[$];
  logic [56:0] pq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Beat k packed as {tdata, tstrb, tkeep, tlast, tid, tdest, tuser}.
  function automatic logic [56:0] mk(input int k, input logic last);
    logic [7:0] b;
    b = k[7:0];
    return {32'hC0DE0000 | 32'(k), b[3:0], ~b[3:0], last, b ^ 8'h5A, b[3:0] + 4'd1,
            b[3:0] ^ 4'h9};
  endfunction

  // One cycle on the stream FIFO; called at posedge+1, returns at the next posedge+1.
  task automatic str_step(input logic vin, input int k, input logic last, input logic rdy,
                          output logic acc);
    logic [56:0] b, obs, dump;
    logic exp_vld, exp_rdy;
    b = mk(k, last);
    s_in.tvalid = vin;
    {s_in.tdata, s_in.tstrb, s_in.tkeep, s_in.tlast, s_in.tid, s_in.tdest, s_in.tuser} = b;
    s_out.tready = rdy;
    #1;
    exp_vld = (sq.size() != 0);
    exp_rdy = (sq.size() < 16);
    obs = {s_out.tdata, s_out.tstrb, s_out.tkeep, s_out.tlast, s_out.tid, s_out.tdest,
           s_out.tuser};
    check("s_used", 64'(s_used), 64'(sq.size()));
    check("s_tvalid", 64'(s_out.tvalid), 64'(exp_vld));
    check("s_tready", 64'(s_in.tready), 64'(exp_rdy));
    if (exp_vld) check("s_data", 64'(obs), 64'(sq[0]));
    acc = vin && exp_rdy;
    @(posedge aclk);
    #1;
    if (exp_vld && rdy) begin
      dump = sq.pop_front();
      s_popped++;
    end
    if (acc) sq.push_back(b);
  endtask

  // One cycle on the packet FIFO with a hand-scheduled expected tvalid.
  task automatic pkt_step(input logic vin, input int k, input logic last, input logic rdy,
                          input logic exp_vld, output logic acc);
    logic [56:0] b, obs, dump;
    logic exp_rdy;
    b = mk(k, last);
    p_in.tvalid = vin;
    {p_in.tdata, p_in.tstrb, p_in.tkeep, p_in.tlast, p_in.tid, p_in.tdest, p_in.tuser} = b;
    p_out.tready = rdy;
    #1;
    exp_rdy = (pq.size() < 8);
    obs = {p_out.tdata, p_out.tstrb, p_out.tkeep, p_out.tlast, p_out.tid, p_out.tdest,
           p_out.tuser};
    check("p_used", 64'(p_used), 64'(pq.size()));
    check("p_tvalid", 64'(p_out.tvalid), 64'(exp_vld));
    check("p_tready", 64'(p_in.tready), 64'(exp_rdy));
    if (exp_vld && pq.size() != 0) check("p_data", 64'(obs), 64'(pq[0]));
    acc = vin && exp_rdy;
    @(posedge aclk);
    #1;
    if (exp_vld && rdy && pq.size() != 0) dump = pq.pop_front();
    if (acc) pq.push_back(b);
  endtask

  initial begin
    logic acc;
    int   k;

    areset       = 1'b1;
    s_in.tvalid  = 1'b0;
    s_out.tready = 1'b0;
    p_in.tvalid  = 1'b0;
    p_out.tready = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    // Reset state
    check("rst_s_tvalid", 64'(s_out.tvalid), 64'd0);
    check("rst_s_tready", 64'(s_in.tready), 64'd0);
    check("rst_s_empty", 64'(s_empty), 64'd1);
    check("rst_s_full", 64'(s_full), 64'd0);
    check("rst_s_used", 64'(s_used), 64'd0);
    check("rst_p_tvalid", 64'(p_out.tvalid), 64'd0);
    check("rst_p_empty", 64'(p_empty), 64'd1);
    #3 areset = 1'b0;
    @(posedge aclk);
    #1;
    check("s_tready_after_rst", 64'(s_in.tready), 64'd1);

    // Stream pass-through with stalls on both sides
    k = 0;
    s_popped = 0;
    for (int c = 0; c < 400 && s_popped < 100; c++) begin
      str_step((k < 100) && (c % 4 != 3), k, (k % 10) == 9, (c % 5 != 1) && (c % 7 != 4),
               acc);
      if (acc) k++;
    end
    check("s_beats_delivered", 64'(s_popped), 64'd100);

    // Fill to full with the output stalled
    for (int i = 0; i < 16; i++) str_step(1'b1, 200 + i, 1'b0, 1'b0, acc);
    check("s_full_after_fill", 64'(s_full), 64'd1);
    check("s_used_after_fill", 64'(s_used), 64'd16);
    check("s_tready_when_full", 64'(s_in.tready), 64'd0);
    check("s_empty_when_full", 64'(s_empty), 64'd0);

    // Simultaneous push/pop long enough to wrap the pointers several times
    k = 216;
    for (int c = 0; c < 40; c++) begin
      str_step(1'b1, k, 1'b0, 1'b1, acc);
      if (acc) k++;
    end
    for (int c = 0; c < 40 && sq.size() != 0; c++) str_step(1'b0, 0, 1'b0, 1'b1, acc);
    check("s_empty_after_drain", 64'(s_empty), 64'd1);

    // Store-and-forward: 5-beat packet, one beat every 3 cycles
    for (int c = 0; c < 13; c++) pkt_step(c % 3 == 0, c / 3, c == 12, 1'b1, 1'b0, acc);
    for (int c = 0; c < 5; c++) pkt_step(1'b0, 0, 1'b0, 1'b1, 1'b1, acc);
    pkt_step(1'b0, 0, 1'b0, 1'b1, 1'b0, acc);
    check("p_empty_after_pkt", 64'(p_empty), 64'd1);

    // Oversize 20-beat packet through an 8-deep buffer
    k = 0;
    for (int c = 0; c < 30; c++) begin
      if (c == 8) check("p_full_oversize", 64'(p_full), 64'd1);
      pkt_step(k < 20, 500 + k, k == 19, 1'b1, (c >= 9) && (c <= 28), acc);
      if (acc) k++;
    end
    check("p_oversize_all_in", 64'(k), 64'd20);

    // Following short packet must be held until its tlast again
    for (int c = 0; c < 7; c++) pkt_step(c < 3, 600 + c, c == 2, 1'b1, (c >= 3) && (c <= 5), acc);

    // tlast pushed while a tlast pops: count stays, tvalid continuous
    for (int c = 0; c < 7; c++)
      pkt_step(c < 4, 700 + c, (c == 1) || (c == 3), 1'b1, (c >= 2) && (c <= 5), acc);

    // Asynchronous reset with 6 beats buffered
    for (int i = 0; i < 6; i++) str_step(1'b1, 300 + i, 1'b0, 1'b0, acc);
    s_in.tvalid = 1'b0;
    #2 areset = 1'b1;
    #1;
    check("amid_s_tvalid", 64'(s_out.tvalid), 64'd0);
    check("amid_s_empty", 64'(s_empty), 64'd1);
    check("amid_s_used", 64'(s_used), 64'd0);
    check("amid_s_tready", 64'(s_in.tready), 64'd0);
    sq.delete();
    #2 areset = 1'b0;
    @(posedge aclk);
    #1;
    check("s_tready_after_rst2", 64'(s_in.tready), 64'd1);
    str_step(1'b1, 400, 1'b1, 1'b1, acc);
    str_step(1'b0, 0, 1'b0, 1'b1, acc);
    check("s_empty_final", 64'(s_empty), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
